// File: rtl/pio_pkg.sv
// pio_pkg: register map and edge-select encodings shared by the PIO block
package pio_pkg;
    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
    localparam int EDGE_NONE    = 0;
    localparam int EDGE_RISING  = 1;
    localparam int EDGE_FALLING = 2;
    localparam int EDGE_ANY     = 3;
endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: pad synchroniser, previous-sample flop, edge select and post-reset warm-up inhibit
module pio_sync_edge import pio_pkg::*; #(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = EDGE_ANY,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edges_o
);
    localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q, rise, fall;
    logic [2:0] cnt_q, cnt_d;
    logic warm;
    // edges only count once the zeroed pipeline has been flushed by real samples
    always_comb begin
        sync_o  = sync_q[SYNC_STAGES-1];
        rise    = sync_o & ~prev_q;
        fall    = ~sync_o & prev_q;
        warm    = cnt_q == WARM;
        cnt_d   = warm ? cnt_q : cnt_q + 3'd1;
        edges_o = !warm                     ? '0 :
                  EDGE_TYPE == EDGE_RISING  ? rise :
                  EDGE_TYPE == EDGE_FALLING ? fall :
                  EDGE_TYPE == EDGE_ANY     ? rise | fall : '0;
    end
    // shift pads through the synchroniser and run the warm-up counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q <= sync_o;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/pio_bidir_irq.sv
// pio_bidir_irq: Avalon-MM bidirectional GPIO with edge capture, maskable irq and atomic set/clear
module pio_bidir_irq import pio_pkg::*; #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               OPEN_DRAIN  = 1'b0,
    parameter int               EDGE_TYPE   = EDGE_ANY,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq
);
    logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0] rdata_q, rdata_d, rsel, sync, edges;
    logic irq_q, irq_d, wr, rd;
    pio_sync_edge #(.WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .reset(reset), .pad_i(pad_in), .sync_o(sync), .edges_o(edges)
    );
    // register writes, read mux on pre-write values, sticky capture where a new edge beats a clear
    always_comb begin
        wr      = chipselect & ~write_n;
        rd      = chipselect & ~read_n;
        data_d  = (wr && address == ADDR_DATA)   ? writedata :
                  (wr && address == ADDR_OUTSET) ? data_q | writedata :
                  (wr && address == ADDR_OUTCLR) ? data_q & ~writedata : data_q;
        dir_d   = (wr && address == ADDR_DIR)     ? writedata : dir_q;
        mask_d  = (wr && address == ADDR_IRQMASK) ? writedata : mask_q;
        cap_d   = (cap_q & ~((wr && address == ADDR_EDGECAP) ? writedata : '0)) | edges;
        rsel    = address == ADDR_DATA    ? sync :
                  address == ADDR_DIR     ? dir_q :
                  address == ADDR_IRQMASK ? mask_q :
                  address == ADDR_EDGECAP ? cap_q : '0;
        rdata_d = rd ? rsel : rdata_q;
        irq_d   = |(cap_q & mask_q);
    end
    // register file, read data and interrupt state
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            dir_q   <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            dir_q   <= dir_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end
    assign pad_out  = OPEN_DRAIN ? '0 : data_q;
    assign pad_oe   = OPEN_DRAIN ? dir_q & ~data_q : dir_q;
    assign readdata = rdata_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_pio_bidir_irq.sv
// tb_pio_bidir_irq: directed table plus edge/irq sequences on a push-pull and an open-drain instance
module tb_pio_bidir_irq;
    logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
    logic [2:0] address = '0;
    logic [7:0] writedata = '0, pad_in = 8'h3C;
    logic [7:0] readdata_a, pad_out_a, pad_oe_a, readdata_b, pad_out_b, pad_oe_b;
    logic irq_a, irq_b;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    pio_bidir_irq #(.WIDTH(8), .RESET_VALUE(8'hA5), .OPEN_DRAIN(1'b0), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read_n(read_n),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a), .pad_in(pad_in),
        .pad_out(pad_out_a), .pad_oe(pad_oe_a), .irq(irq_a));
    pio_bidir_irq #(.WIDTH(8), .RESET_VALUE(8'h00), .OPEN_DRAIN(1'b1), .EDGE_TYPE(3), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read_n(read_n),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_b), .pad_in(pad_in),
        .pad_out(pad_out_b), .pad_oe(pad_oe_b), .irq(irq_b));

    typedef struct {
        logic       wr;
        logic       rd;
        logic [2:0] a;
        logic [7:0] wd, rda, outa, oea, outb, oeb;
    } vec_t;
    vec_t v[15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus(input logic w, input logic r, input logic [2:0] a, input logic [7:0] d);
        chipselect = 1'b1;
        write_n    = ~w;
        read_n     = ~r;
        address    = a;
        writedata  = d;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        read_n     = 1'b1;
    endtask

    initial begin
        v[0]  = '{1'b0, 1'b1, 3'd0, 8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
        v[1]  = '{1'b1, 1'b0, 3'd1, 8'hF0, 8'h3C, 8'hA5, 8'hF0, 8'h00, 8'hF0};
        v[2]  = '{1'b1, 1'b0, 3'd0, 8'h5A, 8'h3C, 8'h5A, 8'hF0, 8'h00, 8'hA0};
        v[3]  = '{1'b1, 1'b0, 3'd4, 8'h01, 8'h3C, 8'h5B, 8'hF0, 8'h00, 8'hA0};
        v[4]  = '{1'b1, 1'b0, 3'd5, 8'h10, 8'h3C, 8'h4B, 8'hF0, 8'h00, 8'hB0};
        v[5]  = '{1'b0, 1'b1, 3'd1, 8'h00, 8'hF0, 8'h4B, 8'hF0, 8'h00, 8'hB0};
        v[6]  = '{1'b0, 1'b1, 3'd4, 8'h00, 8'h00, 8'h4B, 8'hF0, 8'h00, 8'hB0};
        v[7]  = '{1'b0, 1'b1, 3'd0, 8'h00, 8'h3C, 8'h4B, 8'hF0, 8'h00, 8'hB0};
        v[8]  = '{1'b0, 1'b1, 3'd7, 8'h00, 8'h00, 8'h4B, 8'hF0, 8'h00, 8'hB0};
        v[9]  = '{1'b1, 1'b0, 3'd6, 8'hFF, 8'h00, 8'h4B, 8'hF0, 8'h00, 8'hB0};
        v[10] = '{1'b1, 1'b0, 3'd1, 8'h03, 8'h00, 8'h4B, 8'h03, 8'h00, 8'h00};
        v[11] = '{1'b1, 1'b0, 3'd0, 8'h01, 8'h00, 8'h01, 8'h03, 8'h00, 8'h02};
        v[12] = '{1'b1, 1'b0, 3'd5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h03};
        v[13] = '{1'b1, 1'b1, 3'd1, 8'h0F, 8'h03, 8'h00, 8'h0F, 8'h00, 8'h0F};
        v[14] = '{1'b0, 1'b1, 3'd1, 8'h00, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F};

        tick(3);
        check("reset_pad_out", pad_out_a, 8'hA5);
        check("reset_pad_oe", pad_oe_a, 8'h00);
        check("reset_irq", {7'b0, irq_a}, 8'h00);
        check("reset_readdata", readdata_a, 8'h00);
        reset = 1'b0;
        tick(6);

        for (int i = 0; i < 15; i++) begin
            bus(v[i].wr, v[i].rd, v[i].a, v[i].wd);
            check($sformatf("vec%0d_readdata", i), readdata_a, v[i].rda);
            check($sformatf("vec%0d_pad_out_a", i), pad_out_a, v[i].outa);
            check($sformatf("vec%0d_pad_oe_a", i), pad_oe_a, v[i].oea);
            check($sformatf("vec%0d_pad_out_b", i), pad_out_b, v[i].outb);
            check($sformatf("vec%0d_pad_oe_b", i), pad_oe_b, v[i].oeb);
        end

        bus(1'b1, 1'b0, 3'd2, 8'h04);
        pad_in = 8'h38;
        tick(6);
        bus(1'b0, 1'b1, 3'd3, 8'h00);
        check("fall_ignored_a", readdata_a, 8'h00);
        check("fall_captured_b", readdata_b, 8'h04);

        pad_in = 8'h3C;
        tick(3);
        check("rise_irq_not_yet", {7'b0, irq_a}, 8'h00);
        tick(1);
        check("rise_irq_set", {7'b0, irq_a}, 8'h01);
        bus(1'b0, 1'b1, 3'd3, 8'h00);
        check("rise_edgecap", readdata_a, 8'h04);
        bus(1'b1, 1'b0, 3'd3, 8'h04);
        check("clr_irq_lag", {7'b0, irq_a}, 8'h01);
        tick(1);
        check("clr_irq_low", {7'b0, irq_a}, 8'h00);
        bus(1'b0, 1'b1, 3'd3, 8'h00);
        check("clr_edgecap", readdata_a, 8'h00);

        pad_in = 8'h38;
        tick(6);
        pad_in = 8'h3C;
        tick(4);
        check("rearm_irq", {7'b0, irq_a}, 8'h01);
        pad_in = 8'h38;
        tick(6);
        check("rearm_hold_irq", {7'b0, irq_a}, 8'h01);
        pad_in = 8'h3C;
        tick(2);
        bus(1'b1, 1'b0, 3'd3, 8'h04);
        tick(1);
        check("setwins_irq", {7'b0, irq_a}, 8'h01);
        bus(1'b0, 1'b1, 3'd3, 8'h00);
        check("setwins_edgecap", readdata_a, 8'h04);

        pad_in     = 8'hFF;
        reset      = 1'b1;
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 3'd0;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        check("reset_aborts_read", readdata_a, 8'h00);
        check("rereset_pad_out", pad_out_a, 8'hA5);
        tick(1);
        reset = 1'b0;
        tick(10);
        bus(1'b0, 1'b1, 3'd3, 8'h00);
        check("warmup_edgecap_a", readdata_a, 8'h00);
        check("warmup_edgecap_b", readdata_b, 8'h00);
        bus(1'b0, 1'b1, 3'd0, 8'h00);
        check("warmup_data", readdata_a, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
